// File: rtl/fifo_03_11.sv
// Single-clock byte FIFO with registered pop data and count-decoded status flags.
// Overflowing writes and underflowing reads are dropped without side effects.
module fifo_03_11 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [7:0]            address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic [PTR_WIDTH:0]    count;
  logic                  push;
  logic                  pop;

  // Address is reserved for later register access and deliberately unused.
  logic unused_address;
  assign unused_address = ^address;

  // Flags come only from registered state, so they never follow the inputs.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign push  = write & ~full;
  assign pop   = read & ~empty;

  // NOTE: storage has no reset; stale entries are unreachable once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr     <= rptr + 1'b1;
        data_out <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_03_11.sv
// Self-checking bench for fifo_03_11: queue scoreboard on every cycle plus a
// table of fill/overflow/drain vectors with hand-written expected outputs.
module tb_fifo_03_11;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       empty;
  logic       full;
  logic [7:0] data_out;

  fifo_03_11 dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .read     (read),
    .address  (address),
    .data_in  (data_in),
    .empty    (empty),
    .full     (full),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_dout;
  } vec_t;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  string      cur_test = "init";
  logic       rand_addr = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] m_dout = 8'h00;
  vec_t       tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
    end
  endtask

  // Drive one cycle from a negedge, update the scoreboard at the posedge,
  // compare just after it, and return at the following negedge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    logic do_push;
    logic do_pop;
    write   = w;
    read    = r;
    data_in = d;
    address = rand_addr ? 8'($urandom) : 8'h00;
    do_push = w && (sb.size() < 8);
    do_pop  = r && (sb.size() > 0);
    @(posedge clk);
    if (do_pop) m_dout = sb.pop_front();
    if (do_push) sb.push_back(d);
    #1;
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full", 32'(full), 32'(sb.size() == 8));
    check("data_out", 32'(data_out), 32'(m_dout));
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    sb.delete();
    m_dout = 8'h00;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      check($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].e_dout));
    end
  endtask

  initial begin
    logic [7:0] vals[8];
    vals = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd16, 8'd18};
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{w: 1'b1, r: 1'b0, d: vals[i], e_empty: 1'b0, e_full: (i == 7), e_dout: 8'h00};
    end
    tbl[8] = '{w: 1'b1, r: 1'b0, d: 8'd99, e_empty: 1'b0, e_full: 1'b1, e_dout: 8'h00};
    for (int i = 0; i < 8; i++) begin
      tbl[9 + i] = '{w: 1'b0, r: 1'b1, d: 8'h00, e_empty: (i == 7), e_full: 1'b0, e_dout: vals[i]};
    end
    tbl[17] = '{w: 1'b0, r: 1'b1, d: 8'h00, e_empty: 1'b1, e_full: 1'b0, e_dout: 8'd18};

    // Reset held low while inputs toggle.
    cur_test = "reset_hold";
    reset = 1'b0; write = 1'b0; read = 1'b0; address = 8'h00; data_in = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      write   = 1'($urandom);
      read    = 1'($urandom);
      data_in = 8'($urandom);
      @(posedge clk);
      #1;
      check("empty", 32'(empty), 32'd1);
      check("full", 32'(full), 32'd0);
      check("data_out", 32'(data_out), 32'd0);
    end
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    reset = 1'b1;

    cur_test = "fill_drain";
    run_table();

    cur_test = "wrap";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i));
    check("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("wrap_pop%0d", i), 32'(data_out), 32'(8'hA0 + i));
    end

    cur_test = "simul_mid";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    check("mid_drained", 32'(empty), 32'd1);
    check("mid_last", 32'(data_out), 32'h53);

    cur_test = "simul_empty";
    step(1'b1, 1'b1, 8'h66);
    check("hold_dout", 32'(data_out), 32'h53);
    check("not_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("pop_66", 32'(data_out), 32'h66);
    check("empty_again", 32'(empty), 32'd1);

    cur_test = "simul_full";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
    step(1'b1, 1'b1, 8'hEE);
    check("oldest", 32'(data_out), 32'h70);
    check("not_full", 32'(full), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
    check("last", 32'(data_out), 32'h77);
    check("drained", 32'(empty), 32'd1);

    cur_test = "reset_mid";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h90 + i));
    pulse_reset();
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    check("dout_3c", 32'(data_out), 32'h3C);

    cur_test = "addr_rand";
    pulse_reset();
    rand_addr = 1'b1;
    run_table();
    rand_addr = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
